// File: rtl/dbus_port_router.sv
// dbus_port_router: steers NUM_PORTS pipeline dbus requests to NUM_PORTS DCache
// lanes or to one shared uncached port, with fixed kseg0/kseg1 translation, and
// routes data_ok/data back to the originating port with several requests in flight.
// Requests and addr_ok pass straight through; data_ok is combinational from downstream.
// Optional build macro: DBUS_ROUTER_PERF_CNT_EN adds perf_cached/perf_uncached/perf_stall.

package dbus_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;
endpackage

module dbus_port_router
  import dbus_pkg::*;
#(
  parameter int NUM_PORTS   = 2,
  parameter int OUTSTANDING = 2
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  dbus_req_t  [NUM_PORTS-1:0]  dreq,
  output dbus_resp_t [NUM_PORTS-1:0]  dresp,
  output dbus_req_t  [NUM_PORTS-1:0]  creq,
  input  dbus_resp_t [NUM_PORTS-1:0]  cresp,
  output dbus_req_t                   ureq,
  input  dbus_resp_t                  uresp
`ifdef DBUS_ROUTER_PERF_CNT_EN
  ,
  output logic [31:0]                 perf_cached,
  output logic [31:0]                 perf_uncached,
  output logic [31:0]                 perf_stall
`endif
);

  localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int AW    = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CW    = $clog2(OUTSTANDING + 1);
  localparam int DEPTH = 1 << AW;
  localparam logic [CW-1:0] CNT_MAX = CW'(OUTSTANDING);

  // request classification
  logic [31:0]          paddr    [NUM_PORTS];
  logic [NUM_PORTS-1:0] is_unc;
  logic [NUM_PORTS-1:0] cvalid;
  logic [PW-1:0]        lane_of  [NUM_PORTS];
  logic [PW:0]          lane_acc;
  logic [NUM_PORTS-1:0] same_tgt;
  logic [NUM_PORTS-1:0] room;
  logic [NUM_PORTS-1:0] can_issue;

  // acceptance / response events
  logic [NUM_PORTS-1:0] c_acc;
  logic [NUM_PORTS-1:0] c_push;
  logic [PW-1:0]        c_push_id [NUM_PORTS];
  logic [NUM_PORTS-1:0] c_pop;
  logic [NUM_PORTS-1:0] rsp_hit;
  logic                 usel_vld;
  logic [PW-1:0]        usel;
  logic                 u_acc;
  logic                 u_done;

  // per-port and per-lane state
  logic [CW-1:0]        out_cnt   [NUM_PORTS];
  logic [NUM_PORTS-1:0] last_unc;
  logic [PW-1:0]        last_lane [NUM_PORTS];
  logic [PW-1:0]        fmem      [NUM_PORTS][DEPTH];
  logic [AW-1:0]        rptr      [NUM_PORTS];
  logic [AW-1:0]        wptr      [NUM_PORTS];
  logic [CW-1:0]        fcnt      [NUM_PORTS];
  logic                 ubusy;
  logic [PW-1:0]        uowner;

  // translate, classify, and compact valid cached requests onto lanes 0..k
  always_comb begin
    lane_acc = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      paddr[i]   = (dreq[i].addr[31:30] == 2'b10) ? {3'b000, dreq[i].addr[28:0]}
                                                   : dreq[i].addr;
      is_unc[i]  = (dreq[i].addr[31:29] == 3'b101);
      cvalid[i]  = dreq[i].valid && !is_unc[i];
      lane_of[i] = lane_acc[PW-1:0];
      if (cvalid[i]) lane_acc = lane_acc + 1'b1;
    end
  end

  // issue rule: depth limit, single target while in flight, target has room
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      same_tgt[i]  = (out_cnt[i] == '0) ||
                     ((last_unc[i] == is_unc[i]) &&
                      (is_unc[i] || (last_lane[i] == lane_of[i])));
      room[i]      = is_unc[i] ? !ubusy : (fcnt[lane_of[i]] != CNT_MAX);
      can_issue[i] = resetn && dreq[i].valid && (out_cnt[i] != CNT_MAX) &&
                     same_tgt[i] && room[i];
    end
  end

  // uncached arbitration: lowest-index eligible port wins
  always_comb begin
    usel_vld = 1'b0;
    usel     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!usel_vld && is_unc[i] && can_issue[i]) begin
        usel_vld = 1'b1;
        usel     = PW'(i);
      end
    end
  end

  // downstream request drive, addr_ok return and data_ok/data routing
  always_comb begin
    creq      = '0;
    ureq      = '0;
    dresp     = '0;
    c_acc     = '0;
    c_push    = '0;
    c_pop     = '0;
    rsp_hit   = '0;
    u_acc     = 1'b0;
    u_done    = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) c_push_id[i] = '0;

    for (int i = 0; i < NUM_PORTS; i++) begin
      if (cvalid[i] && can_issue[i]) begin
        creq[lane_of[i]]      = dreq[i];
        creq[lane_of[i]].addr = paddr[i];
        c_acc[i]              = cresp[lane_of[i]].addr_ok;
        dresp[i].addr_ok      = c_acc[i];
        if (c_acc[i]) begin
          c_push[lane_of[i]]    = 1'b1;
          c_push_id[lane_of[i]] = PW'(i);
        end
      end
    end

    if (usel_vld) begin
      ureq                = dreq[usel];
      ureq.addr           = paddr[usel];
      u_acc               = uresp.addr_ok;
      dresp[usel].addr_ok = uresp.addr_ok;
    end

    for (int k = 0; k < NUM_PORTS; k++) begin
      c_pop[k] = resetn && cresp[k].data_ok && (fcnt[k] != '0);
      if (c_pop[k]) begin
        dresp[fmem[k][rptr[k]]].data_ok = 1'b1;
        dresp[fmem[k][rptr[k]]].data    = cresp[k].data;
        rsp_hit[fmem[k][rptr[k]]]       = 1'b1;
      end
    end

    u_done = resetn && uresp.data_ok && ubusy;
    if (u_done) begin
      dresp[uowner].data_ok = 1'b1;
      dresp[uowner].data    = uresp.data;
      rsp_hit[uowner]       = 1'b1;
    end
  end

  // lane owner FIFOs and uncached owner tracking
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        rptr[k] <= '0;
        wptr[k] <= '0;
        fcnt[k] <= '0;
      end
      ubusy  <= 1'b0;
      uowner <= '0;
    end else begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (c_push[k]) begin
          fmem[k][wptr[k]] <= c_push_id[k];
          wptr[k]          <= wptr[k] + 1'b1;
        end
        if (c_pop[k]) rptr[k] <= rptr[k] + 1'b1;
        case ({c_push[k], c_pop[k]})
          2'b10:   fcnt[k] <= fcnt[k] + 1'b1;
          2'b01:   fcnt[k] <= fcnt[k] - 1'b1;
          default: fcnt[k] <= fcnt[k];
        endcase
      end
      if (u_acc) begin
        ubusy  <= 1'b1;
        uowner <= usel;
      end else if (u_done) begin
        ubusy <= 1'b0;
      end
    end
  end

  // per-port outstanding count and the target those requests went to
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        out_cnt[i]   <= '0;
        last_lane[i] <= '0;
      end
      last_unc <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        logic inc;
        inc = c_acc[i] || (u_acc && (usel == PW'(i)));
        case ({inc, rsp_hit[i]})
          2'b10:   out_cnt[i] <= out_cnt[i] + 1'b1;
          2'b01:   out_cnt[i] <= out_cnt[i] - 1'b1;
          default: out_cnt[i] <= out_cnt[i];
        endcase
        if (inc) begin
          last_unc[i]  <= is_unc[i];
          last_lane[i] <= lane_of[i];
        end
      end
    end
  end

`ifdef DBUS_ROUTER_PERF_CNT_EN
  logic [31:0] n_cacc;
  logic        stall_any;

  // per-cycle event tallies for the performance counters
  always_comb begin
    n_cacc    = '0;
    stall_any = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      n_cacc = n_cacc + 32'(c_acc[i]);
      if (dreq[i].valid && !dresp[i].addr_ok) stall_any = 1'b1;
    end
  end

  // wrapping event counters, one cycle behind the event
  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_cached   <= '0;
      perf_uncached <= '0;
      perf_stall    <= '0;
    end else begin
      perf_cached   <= perf_cached + n_cacc;
      perf_uncached <= perf_uncached + 32'(u_acc);
      perf_stall    <= perf_stall + 32'(stall_any);
    end
  end
`endif

endmodule

// File: doc/dbus_port_router.md
Name: dbus_port_router

Overview:
- Parametrised successor to the data-side request steering in the cache manager.
- Accepts NUM_PORTS dbus request channels from the pipeline and performs fixed kseg0/kseg1 translation.
- Classifies each request as cached or uncached and steers it to NUM_PORTS DCache lanes or to a single shared uncached dbus port, which feeds DBusToCBus.
- Tracks outstanding requests per lane so that data_ok/data always return to the originating port, with multiple requests in flight.

Parameters:
- NUM_PORTS, 2, number of pipeline dbus ports and DCache lanes (1..4).
- OUTSTANDING, 2, max in-flight cached requests per lane and per port (power of 2, >=1).

Ports:
- clk  in  1  clock.
- resetn  in  1  reset.
- dreq  in  NUM_PORTS x dbus_req_t  pipeline requests; index 0 is oldest/highest priority.
- dresp  out  NUM_PORTS x dbus_resp_t  per-port addr_ok/data_ok/data.
- creq  out  NUM_PORTS x dbus_req_t  DCache lanes, physical address.
- cresp  in  NUM_PORTS x dbus_resp_t  DCache lane responses; in order per lane.
- ureq  out  dbus_req_t  shared uncached request, physical address.
- uresp  in  dbus_resp_t  uncached response.

Behaviour:
- Clock/reset: single clock clk. resetn is synchronous, active-low.
- Translation (combinational):
  - vaddr[31:30]==2'b10 -> paddr={3'b000,vaddr[28:0]}; otherwise paddr=vaddr.
  - Uncached iff vaddr[31:29]==3'b101.
- Per-port state:
  - out_cnt (0..OUTSTANDING).
  - last_tgt {unc, lane}, meaningful only while out_cnt>0.
- Issue rule for port i (all must hold):
  - out_cnt<OUTSTANDING.
  - out_cnt==0, or the new target equals last_tgt.
  - Target FIFO not full: the lane owner FIFO for cached requests, or uncached not busy for uncached requests.
- Cached lane assignment:
  - The k-th valid cached request, by ascending port index, uses lane k. Assignment uses ungated valids.
  - If the port may not issue, creq[k].valid=0 and the lane stays idle that cycle.
  - creq[k] carries the translated request; all fields are zero when not driven.
- Uncached arbitration:
  - Lowest-index port with a valid uncached request that satisfies the issue rule drives ureq; otherwise ureq='0.
  - At most one uncached request in flight: ubusy/uowner set on accept, cleared on uresp.data_ok.
- Acceptance:
  - dresp[i].addr_ok = the issued-to target's addr_ok, gated by the issue rule.
  - On acceptance: push i into lane k owner FIFO (cached) or set uowner=i (uncached); out_cnt++; last_tgt updated.
- Response routing:
  - cresp[k].data_ok pops lane k owner FIFO head h and drives dresp[h].data_ok=1, data=cresp[k].data.
  - uresp.data_ok drives dresp[uowner].
  - out_cnt-- for the receiving port.
  - The issue rule guarantees at most one response source per port per cycle.
  - Ports with no response that cycle: data_ok=0, data=0.
- Simultaneous accept and response, same port, same cycle: out_cnt unchanged; FIFO push and pop both occur. A full FIFO does not accept even if it pops that cycle (no bypass).
- Spurious responses: data_ok on an empty lane FIFO, or on uresp when not busy, is ignored.
- Reset:
  - All counters, FIFOs, ubusy cleared; all outputs '0 in the reset cycle.
  - Requests in flight when reset is asserted are dropped. Downstream data_ok arriving after reset is ignored under the spurious-response rule.
- Latency: zero added cycles. Request and addr_ok are combinational pass-through; data_ok is combinational from downstream.

Optional Feature:
- Macro: DBUS_ROUTER_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_cached (32), perf_uncached (32), perf_stall (32).
  - Counts accepted cached requests, accepted uncached requests, and cycles where any port has valid=1 without addr_ok.
  - Counters wrap at 2^32, clear on reset, and update one cycle after the event.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Translation: port0 load 0x8000_1000, cresp[0] addr_ok=1 -> creq[0].addr=0x0000_1000, valid; next cycle cresp[0].data_ok with data 0xDEAD_BEEF -> dresp[0].data_ok=1, data=0xDEAD_BEEF; dresp[1] stays 0.
- Compaction: port0 valid at 0xA000_0000 (uncached), port1 valid at 0x8000_0040 (cached) -> ureq.addr=0x0000_0000 from port0; creq[0] carries port1's 0x0000_0040; creq[1].valid=0; responses return to the correct ports.
- Uncached serialisation: both ports issue uncached -> port0 accepted; port1 addr_ok=0 until the cycle after uresp.data_ok, then accepted.
- Depth limit: OUTSTANDING=2, port0 issues 3 cached requests with no data_ok -> third addr_ok=0; data_ok in the same cycle as the third attempt -> still stalled that cycle (no bypass), accepted next cycle.
- Target switch: port0 has 1 cached request outstanding on lane0, then requests uncached -> stalled until lane0 data_ok, then issued to ureq.
- Reset mid-flight: 2 requests outstanding, resetn=0 for 1 cycle, then cresp[0].data_ok=1 -> no dresp data_ok; a fresh request is accepted immediately.
